// File: rtl/sdram_arbiter.sv
// SDRAM logical-port arbiter: SPI flash-emulator reads (strict priority) and
// host loader reads/writes share one edge-triggered controller port. Also
// drives refresh_inhibit from spi_active with a watchdog on its duration.
module sdram_arbiter #(
  parameter int ADDR_WIDTH    = 25,
  parameter int INHIBIT_LIMIT = 4096,
  parameter int START_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_active,
  input  logic                  spi_rd_req,
  input  logic [ADDR_WIDTH-1:0] spi_rd_addr,
  output logic [7:0]            spi_rd_data,
  output logic                  spi_rd_valid,
  output logic                  spi_overrun,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [7:0]            host_wdata,
  output logic                  host_ack,
  output logic [7:0]            host_rdata,
  output logic                  host_rvalid,
  output logic [ADDR_WIDTH-1:0] sd_rd_addr,
  output logic                  sd_rd_enable,
  output logic [ADDR_WIDTH-1:0] sd_wr_addr,
  output logic [7:0]            sd_wr_data,
  output logic                  sd_wr_enable,
  input  logic [7:0]            sd_rd_data,
  input  logic                  sd_rd_ready,
  input  logic                  sd_busy,
  output logic                  sd_refresh_inhibit
);

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int IW = $clog2(INHIBIT_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t                  state, state_next;
  logic [TW-1:0]           start_cnt;
  logic                    issue_spi, issue_retry, issue_host;

  logic                    spi_pend;
  logic [ADDR_WIDTH-1:0]   spi_pend_addr;
  logic [ADDR_WIDTH-1:0]   spi_issue_addr;

  logic                    host_pend;
  logic                    host_we_q;
  logic [ADDR_WIDTH-1:0]   host_addr_q;
  logic [7:0]              host_wdata_q;

  logic                    cmd_we;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [7:0]              cmd_wdata;

  logic                    owner_host;
  logic                    op_we;
  logic                    rd_capture;

  logic [IW-1:0]           inh_cnt;
  logic                    inh_blocked;

  // A request pulsing in the same cycle it is chosen bypasses the latch so SPI
  // still wins a same-cycle race against the host.
  assign spi_issue_addr = spi_pend ? spi_pend_addr : spi_rd_addr;
  assign rd_capture     = (state == WAIT_DONE) && sd_rd_ready && !op_we;

  // State register and WAIT_START timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      start_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == WAIT_START) start_cnt <= start_cnt + TW'(1);
      else                     start_cnt <= '0;
    end
  end

  // Next-state and requester selection.
  always_comb begin
    state_next  = state;
    issue_spi   = 1'b0;
    issue_retry = 1'b0;
    issue_host  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!sd_busy) begin
          if (spi_pend || spi_rd_req)        issue_spi   = 1'b1;
          else if (host_pend)                issue_retry = 1'b1;
          else if (host_req && !spi_active)  issue_host  = 1'b1;
          if (issue_spi || issue_retry || issue_host) state_next = ISSUE;
        end
      end
      ISSUE:      state_next = WAIT_START;
      WAIT_START: begin
        if (sd_busy) state_next = WAIT_DONE;
        else if (start_cnt == TW'(START_TIMEOUT - 1)) state_next = IDLE;
      end
      WAIT_DONE:  if (!sd_busy) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Host command source: live inputs for a fresh request, saved copy for a re-issue.
  always_comb begin
    cmd_we    = host_we_q;
    cmd_addr  = host_addr_q;
    cmd_wdata = host_wdata_q;
    if (issue_host) begin
      cmd_we    = host_we;
      cmd_addr  = host_addr;
      cmd_wdata = host_wdata;
    end
  end

  // SPI pending latch; it covers the whole read until its data is returned.
  always_ff @(posedge clk) begin
    if (reset) begin
      spi_pend      <= 1'b0;
      spi_pend_addr <= '0;
      spi_overrun   <= 1'b0;
    end else begin
      spi_overrun <= spi_rd_req && spi_pend;
      if (spi_rd_req && !spi_pend) begin
        spi_pend      <= 1'b1;
        spi_pend_addr <= spi_rd_addr;
      end else if (rd_capture && !owner_host) begin
        spi_pend <= 1'b0;
      end
    end
  end

  // Host copy, kept after host_ack so a start timeout can re-issue without the host.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_pend    <= 1'b0;
      host_we_q    <= 1'b0;
      host_addr_q  <= '0;
      host_wdata_q <= '0;
    end else if (issue_host) begin
      host_pend    <= 1'b1;
      host_we_q    <= host_we;
      host_addr_q  <= host_addr;
      host_wdata_q <= host_wdata;
    end else if (state == WAIT_DONE && !sd_busy && owner_host) begin
      host_pend <= 1'b0;
    end
  end

  // Command outputs: enables high only during ISSUE, address/data held afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      sd_rd_enable <= 1'b0;
      sd_wr_enable <= 1'b0;
      host_ack     <= 1'b0;
      sd_rd_addr   <= '0;
      sd_wr_addr   <= '0;
      sd_wr_data   <= '0;
      owner_host   <= 1'b0;
      op_we        <= 1'b0;
    end else begin
      sd_rd_enable <= 1'b0;
      sd_wr_enable <= 1'b0;
      host_ack     <= 1'b0;
      if (issue_spi) begin
        sd_rd_enable <= 1'b1;
        sd_rd_addr   <= spi_issue_addr;
        owner_host   <= 1'b0;
        op_we        <= 1'b0;
      end else if (issue_retry || issue_host) begin
        owner_host <= 1'b1;
        op_we      <= cmd_we;
        host_ack   <= issue_host;
        if (cmd_we) begin
          sd_wr_enable <= 1'b1;
          sd_wr_addr   <= cmd_addr;
          sd_wr_data   <= cmd_wdata;
        end else begin
          sd_rd_enable <= 1'b1;
          sd_rd_addr   <= cmd_addr;
        end
      end
    end
  end

  // Read return: capture data and pulse the owner's valid one cycle after rd_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      spi_rd_valid <= 1'b0;
      spi_rd_data  <= '0;
      host_rvalid  <= 1'b0;
      host_rdata   <= '0;
    end else begin
      spi_rd_valid <= rd_capture && !owner_host;
      host_rvalid  <= rd_capture && owner_host;
      if (rd_capture && !owner_host) spi_rd_data <= sd_rd_data;
      if (rd_capture && owner_host)  host_rdata  <= sd_rd_data;
    end
  end

  // Refresh inhibit follows spi_active until the watchdog trips; rearms on spi_active low.
  always_ff @(posedge clk) begin
    if (reset) begin
      sd_refresh_inhibit <= 1'b0;
      inh_cnt            <= '0;
      inh_blocked        <= 1'b0;
    end else if (!spi_active) begin
      sd_refresh_inhibit <= 1'b0;
      inh_cnt            <= '0;
      inh_blocked        <= 1'b0;
    end else if (inh_blocked) begin
      sd_refresh_inhibit <= 1'b0;
    end else if (sd_refresh_inhibit && inh_cnt == IW'(INHIBIT_LIMIT - 1)) begin
      sd_refresh_inhibit <= 1'b0;
      inh_blocked        <= 1'b1;
    end else begin
      sd_refresh_inhibit <= 1'b1;
      if (sd_refresh_inhibit) inh_cnt <= inh_cnt + IW'(1);
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: behavioural SDRAM controller model,
// command/read-result scoreboards, a vector table and hand-written corner sequences.
module tb_sdram_arbiter;
  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset;
  logic          spi_active, spi_rd_req;
  logic [AW-1:0] spi_rd_addr;
  logic [7:0]    spi_rd_data;
  logic          spi_rd_valid, spi_overrun;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_ack;
  logic [7:0]    host_rdata;
  logic          host_rvalid;
  logic [AW-1:0] sd_rd_addr, sd_wr_addr;
  logic          sd_rd_enable, sd_wr_enable;
  logic [7:0]    sd_wr_data, sd_rd_data;
  logic          sd_rd_ready, sd_busy, sd_refresh_inhibit;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_WIDTH(AW), .INHIBIT_LIMIT(4096), .START_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .spi_active(spi_active), .spi_rd_req(spi_rd_req), .spi_rd_addr(spi_rd_addr),
    .spi_rd_data(spi_rd_data), .spi_rd_valid(spi_rd_valid), .spi_overrun(spi_overrun),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .sd_rd_addr(sd_rd_addr), .sd_rd_enable(sd_rd_enable),
    .sd_wr_addr(sd_wr_addr), .sd_wr_data(sd_wr_data), .sd_wr_enable(sd_wr_enable),
    .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy),
    .sd_refresh_inhibit(sd_refresh_inhibit)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  typedef struct { logic we; logic [AW-1:0] addr; logic [7:0] data; } cmd_t;
  typedef struct { logic host; logic [7:0] data; } res_t;
  cmd_t cmd_q[$];
  res_t res_q[$];

  // controller model state
  logic [7:0] mem [int];
  int   busy_len = 4;
  int   busy_cnt = 0;
  int   drop     = 0;
  logic started  = 1'b0;
  logic m_we;
  int   m_addr;
  logic [7:0] m_data;
  int   n_done = 0, n_rise = 0, n_ack = 0, n_spi_v = 0, n_host_v = 0, n_ovr = 0;

  function automatic logic [7:0] mem_rd(input int a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // Monitor first (sees what the DUT sampled on the last posedge), then model update.
  initial begin
    logic prev_rd, prev_wr, low_rd, low_wr, rr, rw;
    cmd_t e;
    res_t r;
    prev_rd = 0; prev_wr = 0; low_rd = 0; low_wr = 0;
    sd_busy = 0; sd_rd_ready = 0; sd_rd_data = 8'h00;
    mem[32'h0123456] = 8'hA5;
    forever begin
      @(negedge clk);
      rr = (sd_rd_enable === 1'b1) && !prev_rd;
      rw = (sd_wr_enable === 1'b1) && !prev_wr;
      if (low_rd) check("rd_enable_one_cycle", sd_rd_enable, 0);
      if (low_wr) check("wr_enable_one_cycle", sd_wr_enable, 0);
      low_rd = rr; low_wr = rw;
      prev_rd = sd_rd_enable; prev_wr = sd_wr_enable;
      if (rr || rw) begin
        n_rise++;
        check("enable_exclusive", {sd_rd_enable, sd_wr_enable}, rr ? 2 : 1);
        check("issue_while_busy", sd_busy, 0);
        if (drop > 0) drop--;
        else begin
          check("cmd_expected", cmd_q.size() != 0, 1);
          if (cmd_q.size() != 0) begin
            e = cmd_q.pop_front();
            check("cmd_we", rw, e.we);
            check("cmd_addr", rw ? sd_wr_addr : sd_rd_addr, e.addr);
            if (rw) check("cmd_wdata", sd_wr_data, e.data);
            started = 1'b1;
            busy_cnt = busy_len;
            m_we = rw;
            m_addr = rw ? int'(sd_wr_addr) : int'(sd_rd_addr);
            m_data = sd_wr_data;
          end
        end
      end
      if (spi_rd_valid || host_rvalid) begin
        check("valid_after_ready", sd_rd_ready, 1);
        check("valid_exclusive", spi_rd_valid & host_rvalid, 0);
        check("valid_expected", res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          check("valid_owner", host_rvalid, r.host);
          check("valid_data", host_rvalid ? host_rdata : spi_rd_data, r.data);
        end
        if (spi_rd_valid) n_spi_v++;
        if (host_rvalid) n_host_v++;
      end
      if (host_ack) n_ack++;
      if (spi_overrun) n_ovr++;
      // model
      sd_rd_ready = 1'b0;
      if (started) begin
        sd_busy = 1'b1;
        started = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 1 && !m_we) begin
          sd_rd_ready = 1'b1;
          sd_rd_data  = mem_rd(m_addr);
        end
        if (busy_cnt == 0) begin
          sd_busy = 1'b0;
          if (m_we) mem[m_addr] = m_data;
          n_done++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  typedef struct { int kind; int addr; int wdata; int expd; int drop; } vec_t;
  int exp_done = 0, exp_rise = 0, exp_ack = 0, exp_spi = 0, exp_hv = 0;

  task automatic wait_ack(input string name);
    logic got;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (host_ack) begin got = 1; break; end
    end
    check(name, got, 1);
    @(negedge clk);
    host_req = 0;
  endtask

  task automatic host_op(input logic we, input int addr, input int wdata);
    host_we = we; host_addr = AW'(addr); host_wdata = 8'(wdata); host_req = 1;
    wait_ack("host_ack_seen");
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (n_done >= exp_done) break;
    end
    check(name, n_done >= exp_done, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_ctl"}, {spi_rd_data, spi_rd_valid, spi_overrun, host_ack, host_rdata,
                           host_rvalid, sd_rd_enable, sd_wr_enable, sd_wr_data,
                           sd_refresh_inhibit}, 0);
    check({name, "_addr"}, {sd_rd_addr, sd_wr_addr}, 0);
  endtask

  initial begin
    vec_t tab[10];
    int ack0, ovr0, hi, rises;
    logic prev, got;

    tab[0] = '{kind:0, addr:'h0123456, wdata:0,    expd:'hA5, drop:0};
    tab[1] = '{kind:1, addr:'h1000,    wdata:'h3C, expd:0,    drop:0};
    tab[2] = '{kind:2, addr:'h1000,    wdata:0,    expd:'h3C, drop:0};
    tab[3] = '{kind:1, addr:'h1FFFFFF, wdata:'h81, expd:0,    drop:1};
    tab[4] = '{kind:2, addr:'h1FFFFFF, wdata:0,    expd:'h81, drop:0};
    tab[5] = '{kind:0, addr:'h1000,    wdata:0,    expd:'h3C, drop:1};
    tab[6] = '{kind:0, addr:'h0,       wdata:0,    expd:'h00, drop:0};
    tab[7] = '{kind:1, addr:'h0,       wdata:'hFF, expd:0,    drop:0};
    tab[8] = '{kind:2, addr:'h0,       wdata:0,    expd:'hFF, drop:1};
    tab[9] = '{kind:0, addr:'h0,       wdata:0,    expd:'hFF, drop:0};

    reset = 1; spi_active = 0; spi_rd_req = 0; spi_rd_addr = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    reset = 0;
    repeat (2) @(negedge clk);

    // vector table
    for (int i = 0; i < 10; i++) begin
      drop = tab[i].drop;
      exp_rise += 1 + tab[i].drop;
      exp_done++;
      case (tab[i].kind)
        0: begin
          cmd_q.push_back('{we:1'b0, addr:AW'(tab[i].addr), data:8'h00});
          res_q.push_back('{host:1'b0, data:8'(tab[i].expd)});
          spi_active = 1; spi_rd_req = 1; spi_rd_addr = AW'(tab[i].addr);
          @(negedge clk);
          spi_rd_req = 0;
          exp_spi++;
        end
        1: begin
          cmd_q.push_back('{we:1'b1, addr:AW'(tab[i].addr), data:8'(tab[i].wdata)});
          host_op(1'b1, tab[i].addr, tab[i].wdata);
          exp_ack++;
        end
        default: begin
          cmd_q.push_back('{we:1'b0, addr:AW'(tab[i].addr), data:8'h00});
          res_q.push_back('{host:1'b1, data:8'(tab[i].expd)});
          host_op(1'b0, tab[i].addr, 0);
          exp_ack++; exp_hv++;
        end
      endcase
      wait_done("table_op_done");
      spi_active = 0;
      @(negedge clk);
    end
    check("table_spi_valid_count", n_spi_v, exp_spi);
    check("table_host_valid_count", n_host_v, exp_hv);
    check("table_ack_count", n_ack, exp_ack);

    // same-cycle SPI and host: SPI first, host held off while spi_active
    cmd_q.push_back('{we:1'b0, addr:AW'('h0123456), data:8'h00});
    res_q.push_back('{host:1'b0, data:8'hA5});
    cmd_q.push_back('{we:1'b1, addr:AW'('h2000), data:8'h5A});
    ack0 = n_ack;
    spi_active = 1; spi_rd_req = 1; spi_rd_addr = AW'('h0123456);
    host_req = 1; host_we = 1; host_addr = AW'('h2000); host_wdata = 8'h5A;
    @(negedge clk);
    spi_rd_req = 0;
    exp_done++;
    wait_done("same_cycle_spi_done");
    repeat (5) @(negedge clk);
    check("host_starved_while_spi_active", n_ack, ack0);
    spi_active = 0;
    wait_ack("same_cycle_host_ack");
    exp_done++;
    wait_done("same_cycle_host_done");
    check("same_cycle_write_data", mem_rd('h2000), 8'h5A);
    exp_rise += 2; exp_ack++; exp_spi++;

    // second SPI request while the first is in flight
    ovr0 = n_ovr;
    cmd_q.push_back('{we:1'b0, addr:AW'('h1000), data:8'h00});
    res_q.push_back('{host:1'b0, data:8'h3C});
    spi_active = 1; spi_rd_req = 1; spi_rd_addr = AW'('h1000);
    @(negedge clk);
    spi_rd_req = 0;
    repeat (2) @(negedge clk);
    spi_rd_req = 1; spi_rd_addr = AW'('h0BAD);
    @(negedge clk);
    spi_rd_req = 0;
    check("overrun_pulse", spi_overrun, 1);
    @(negedge clk);
    check("overrun_one_cycle", spi_overrun, 0);
    exp_done++;
    wait_done("overrun_read_done");
    spi_active = 0;
    check("overrun_count", n_ovr, ovr0 + 1);
    exp_rise++; exp_spi++;

    // reset while the controller is busy with a host write
    busy_len = 12;
    cmd_q.push_back('{we:1'b1, addr:AW'('h3000), data:8'h11});
    host_op(1'b1, 'h3000, 'h11);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sd_busy) begin got = 1; break; end
    end
    check("reset_test_busy_seen", got, 1);
    @(negedge clk);
    cmd_q.push_back('{we:1'b1, addr:AW'('h3004), data:8'h22});
    host_req = 1; host_we = 1; host_addr = AW'('h3004); host_wdata = 8'h22;
    reset = 1;
    @(negedge clk);
    check_zero_outputs("reset_mid_op");
    reset = 0;
    wait_ack("post_reset_host_ack");
    exp_done += 2;
    wait_done("post_reset_done");
    busy_len = 4;
    check("post_reset_write_data", mem_rd('h3004), 8'h22);
    exp_rise += 2; exp_ack += 2;

    // refresh-inhibit watchdog
    repeat (3) @(negedge clk);
    spi_active = 1;
    hi = 0; rises = 0; prev = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (sd_refresh_inhibit) hi++;
      if (sd_refresh_inhibit && !prev) rises++;
      prev = sd_refresh_inhibit;
    end
    check("inhibit_high_cycles", hi, 4096);
    check("inhibit_single_window", rises, 1);
    check("inhibit_forced_low", sd_refresh_inhibit, 0);
    spi_active = 0;
    repeat (2) @(negedge clk);
    check("inhibit_low_after_drop", sd_refresh_inhibit, 0);
    spi_active = 1;
    @(negedge clk);
    check("inhibit_reasserts", sd_refresh_inhibit, 1);
    spi_active = 0;
    repeat (3) @(negedge clk);

    check("final_cmd_queue_empty", cmd_q.size(), 0);
    check("final_result_queue_empty", res_q.size(), 0);
    check("final_enable_rises", n_rise, exp_rise);
    check("final_ack_count", n_ack, exp_ack);
    check("final_spi_valid_count", n_spi_v, exp_spi);
    check("final_overrun_count", n_ovr, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
